// File: rtl/text_render_scheduler.sv
// Text-mode render scheduler: walks every text cell, assembles its glyph grid and
// colours from the text buffer, font ROM and palette, then runs the shape renderer once per cell.
module text_render_scheduler #(
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 30,
    parameter int unsigned W           = 8,
    parameter int unsigned H           = 16,
    parameter int unsigned LINE_STRIDE = 640,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned COLOR_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  fb_base,
    output logic [11:0]        text_addr,
    input  logic [15:0]        text_data,
    output logic [11:0]        font_addr,
    input  logic [W-1:0]       font_data,
    input  logic               pal_we,
    input  logic [3:0]         pal_idx,
    input  logic [COLOR_W-1:0] pal_data,
    output logic [W*H-1:0]     grid_shape,
    output logic [COLOR_W-1:0] grid_fg,
    output logic [COLOR_W-1:0] grid_bg,
    output logic [ADDR_W-1:0]  base_addr,
    output logic               render_run,
    input  logic               render_done,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned KW = $clog2(H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [KW-1:0] FONT_END = KW'(H);
    localparam logic [KW-1:0] ADDR_END = KW'(H - 1);

    typedef enum logic [2:0] {
        StIdle, StFetchCell, StLatchCell, StFont, StRun, StNext
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [KW-1:0]       font_cnt_q;
    logic [KW-1:0]       shape_row;
    logic [ADDR_W-1:0]   fb_base_q;
    logic [COLOR_W-1:0]  pal_q [16];
    logic [31:0]         cell_off;
    logic                last_cell;

    assign last_cell = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Font data for row k arrives one cycle after its address, so the capture lags by one.
    assign shape_row = font_cnt_q - KW'(1);

    // Framebuffer offset of the current cell's top-left pixel
    always_comb begin
        cell_off = 32'(row_q) * 32'(H * LINE_STRIDE) + 32'(col_q) * 32'(W);
    end

    // State register; async reset also drops render_run immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (start) state_d = StFetchCell;
            StFetchCell: state_d = StLatchCell;
            StLatchCell: state_d = StFont;
            StFont:      if (font_cnt_q == FONT_END) state_d = StRun;
            StRun:       if (render_done) state_d = StNext;
            StNext:      state_d = last_cell ? StIdle : StFetchCell;
            default:     state_d = StIdle;
        endcase
    end

    // FSM outputs; frame_done and busy release share the last cell's NEXT cycle
    always_comb begin
        render_run = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: ;
            StRun: begin
                render_run = 1'b1;
                busy       = 1'b1;
            end
            StNext: begin
                busy       = ~last_cell;
                frame_done = last_cell;
            end
            default: busy = 1'b1;
        endcase
    end

    // Cell walk, glyph assembly and colour/address latching
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            font_cnt_q <= '0;
            fb_base_q  <= '0;
            text_addr  <= '0;
            font_addr  <= '0;
            grid_shape <= '0;
            grid_fg    <= '0;
            grid_bg    <= '0;
            base_addr  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        col_q     <= '0;
                        row_q     <= '0;
                        text_addr <= '0;
                        fb_base_q <= fb_base;
                    end
                end
                StLatchCell: begin
                    // Registered palette read: a write in this same cycle lands after the read.
                    grid_fg    <= pal_q[text_data[11:8]];
                    grid_bg    <= pal_q[text_data[15:12]];
                    font_addr  <= 12'(32'(text_data[7:0]) * H);
                    base_addr  <= fb_base_q + cell_off[ADDR_W-1:0];
                    font_cnt_q <= '0;
                end
                StFont: begin
                    font_cnt_q <= font_cnt_q + KW'(1);
                    if (font_cnt_q < ADDR_END) font_addr <= font_addr + 12'd1;
                    if (font_cnt_q != '0) grid_shape[shape_row*W +: W] <= font_data;
                end
                StNext: begin
                    if (!last_cell) begin
                        text_addr <= text_addr + 12'd1;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Palette storage, writable at any time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= '0;
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_data;
        end
    end

endmodule

// File: tb/tb_text_render_scheduler.sv
// Bench for text_render_scheduler on a 4x2 screen with text/font memory and renderer models.
module tb_text_render_scheduler;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int NCELL = COLS * ROWS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [19:0]  fb_base = '0;
    logic [11:0]  text_addr;
    logic [15:0]  text_data = '0;
    logic [11:0]  font_addr;
    logic [7:0]   font_data = '0;
    logic         pal_we = 1'b0;
    logic [3:0]   pal_idx = '0;
    logic [31:0]  pal_data = '0;
    logic [127:0] grid_shape;
    logic [31:0]  grid_fg, grid_bg;
    logic [19:0]  base_addr;
    logic         render_run, render_done, busy, frame_done;

    always #5 clk = ~clk;

    text_render_scheduler #(
        .COLS(COLS), .ROWS(ROWS), .W(8), .H(16), .LINE_STRIDE(640), .ADDR_W(20), .COLOR_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .fb_base(fb_base),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .grid_shape(grid_shape), .grid_fg(grid_fg), .grid_bg(grid_bg),
        .base_addr(base_addr), .render_run(render_run), .render_done(render_done),
        .busy(busy), .frame_done(frame_done)
    );

    function automatic logic [7:0] font_fn(input logic [11:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd40503;
        return t[15:8] ^ a[7:0];
    endfunction

    // Text buffer and font ROM with one-cycle read latency
    logic [15:0] text_mem [NCELL];
    always @(posedge clk) text_data <= text_mem[text_addr[2:0]];
    always @(posedge clk) font_data <= font_fn(font_addr);

    // Renderer model: done pulse after done_lat cycles of being released
    int   rcnt = 0;
    int   done_lat = 5;
    logic rd_model = 1'b0;
    logic spurious = 1'b0;
    always @(posedge clk) begin
        if (!render_run) begin
            rcnt <= 0;
            rd_model <= 1'b0;
        end else begin
            rcnt <= rcnt + 1;
            rd_model <= (rcnt == done_lat - 1);
        end
    end
    assign render_done = rd_model | spurious;

    // Observation of RUN windows and frame_done pulses
    int           cyc = 0;
    int           n_run = 0, fd_cnt = 0, fd_cyc = 0;
    logic         fd_busy = 1'b0, run_prev = 1'b0;
    logic [31:0]  obs_fg [128], obs_bg [128];
    logic [19:0]  obs_base [128];
    logic [127:0] obs_shape [128];
    int           obs_rise [128], obs_done [128];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        run_prev <= render_run;
        if (render_run && !run_prev && n_run < 128) begin
            obs_fg[n_run]    <= grid_fg;
            obs_bg[n_run]    <= grid_bg;
            obs_base[n_run]  <= base_addr;
            obs_shape[n_run] <= grid_shape;
            obs_rise[n_run]  <= cyc;
            n_run <= n_run + 1;
        end
        if (render_run && render_done && n_run > 0) obs_done[n_run-1] <= cyc;
        if (frame_done) begin
            fd_cnt  <= fd_cnt + 1;
            fd_cyc  <= cyc;
            fd_busy <= busy;
        end
    end

    // Reference model: expected per-cell outputs from buffer, palette and base
    logic [31:0]  pal_m [16];
    logic [19:0]  fb_m;
    logic [31:0]  exp_fg [NCELL], exp_bg [NCELL];
    logic [19:0]  exp_base [NCELL];
    logic [127:0] exp_shape [NCELL];
    int total = 0, bad = 0;

    task automatic build_model(input int from);
        for (int i = from; i < NCELL; i++) begin
            int r, c;
            r = i / COLS;
            c = i % COLS;
            exp_fg[i]   = pal_m[text_mem[i][11:8]];
            exp_bg[i]   = pal_m[text_mem[i][15:12]];
            exp_base[i] = 20'(32'(fb_m) + r * 16 * 640 + c * 8);
            for (int k = 0; k < 16; k++)
                exp_shape[i][k*8 +: 8] = font_fn(12'(32'(text_mem[i][7:0]) * 16 + k));
        end
    endtask

    task automatic pal_write(input logic [3:0] idx, input logic [31:0] data);
        pal_we = 1'b1; pal_idx = idx; pal_data = data;
        @(negedge clk);
        pal_we = 1'b0;
        pal_m[idx] = data;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input logic [19:0] fb, output bit ok);
        fb_base = fb;
        fb_m = fb;
        build_model(0);
        pulse_start();
        wait_frame(ok);
    endtask

    task automatic random_setup();
        for (int i = 0; i < NCELL; i++) text_mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i += 3) pal_write(4'(i), $urandom);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) pal_m[i] = '0;
        for (int i = 0; i < NCELL; i++) text_mem[i] = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({render_run, busy, frame_done} !== 3'b0) begin bad++;
            $display("FAIL reset_ctl: got %b want 000", {render_run, busy, frame_done}); end
        total++; if ({text_addr, font_addr} !== 24'h0) begin bad++;
            $display("FAIL reset_addr: got %h want 0", {text_addr, font_addr}); end
        total++; if ({grid_shape, grid_fg, grid_bg, base_addr} !== '0) begin bad++;
            $display("FAIL reset_grid: got %h/%h/%h want 0", grid_fg, grid_bg, base_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_cell();
        bit ok;
        int errs;
        done_lat = 6;
        random_setup();
        pal_write(4'd1, 32'h00FF_FFFF);
        pal_write(4'd0, 32'h0);
        text_mem[0] = 16'h0141;
        fb_base = 20'($urandom);
        fb_m = fb_base;
        build_model(0);
        pulse_start();
        total++; if (text_addr !== 12'h0 || busy !== 1'b1) begin bad++;
            $display("FAIL fetch_cell0: got addr %h busy %b want 000 1", text_addr, busy); end
        errs = 0;
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk);
            if (j >= 2 && j <= 17) begin
                total++; if (font_addr !== 12'(12'h410 + j - 2)) begin bad++;
                    $display("FAIL font_addr_k%0d: got %h want %h", j - 2, font_addr, 12'h410 + j - 2);
                end
            end
            if (j <= 18 && render_run !== 1'b0) errs++;
        end
        total++; if (errs != 0 || render_run !== 1'b1) begin bad++;
            $display("FAIL run_rise_19: early %0d run %b want 0 1", errs, render_run); end
        total++; if (grid_fg !== 32'h00FF_FFFF || grid_bg !== 32'h0) begin bad++;
            $display("FAIL cell0_colour: got %h/%h want 00ffffff/0", grid_fg, grid_bg); end
        total++; if (base_addr !== fb_m) begin bad++;
            $display("FAIL cell0_base: got %h want %h", base_addr, fb_m); end
        total++; if (grid_shape !== exp_shape[0]) begin bad++;
            $display("FAIL cell0_shape: got %h want %h", grid_shape, exp_shape[0]); end
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_frame_end: got timeout want frame_done"); end
    endtask

    task automatic test_full_frame();
        bit ok;
        int n0, f0;
        done_lat = 128;
        random_setup();
        n0 = n_run; f0 = fd_cnt;
        run_frame(20'($urandom), ok);
        total++; if (!ok) begin bad++; $display("FAIL full_frame_end: got timeout want frame_done"); end
        total++; if (n_run - n0 != NCELL) begin bad++;
            $display("FAIL full_windows: got %0d want %0d", n_run - n0, NCELL); end
        total++; if (fd_cnt - f0 != 1 || fd_busy !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL full_fd: got cnt %0d busy %b/%b want 1 0/0", fd_cnt - f0, fd_busy, busy); end
        total++; if (fd_cyc != obs_done[n0+NCELL-1] + 1) begin bad++;
            $display("FAIL full_fd_time: got %0d want %0d", fd_cyc, obs_done[n0+NCELL-1] + 1); end
        total++; if (obs_base[n0+7] !== 20'(32'(fb_m) + 16 * 640 + 24)) begin bad++;
            $display("FAIL base_r1c3: got %h want %h", obs_base[n0+7], 20'(32'(fb_m) + 10264)); end
        for (int i = 0; i < NCELL; i++) begin
            total++; if ({obs_fg[n0+i], obs_bg[n0+i], obs_base[n0+i], obs_shape[n0+i]} !==
                         {exp_fg[i], exp_bg[i], exp_base[i], exp_shape[i]}) begin bad++;
                $display("FAIL full_cell%0d: got %h %h %h want %h %h %h", i, obs_fg[n0+i],
                         obs_bg[n0+i], obs_base[n0+i], exp_fg[i], exp_bg[i], exp_base[i]); end
            total++; if (obs_done[n0+i] - obs_rise[n0+i] != 128) begin bad++;
                $display("FAIL full_run_len%0d: got %0d want 128", i,
                         obs_done[n0+i] - obs_rise[n0+i]); end
            if (i > 0) begin
                total++; if (obs_rise[n0+i] - obs_done[n0+i-1] != 21) begin bad++;
                    $display("FAIL full_gap%0d: got %0d want 21", i,
                             obs_rise[n0+i] - obs_done[n0+i-1]); end
            end
        end
        repeat (3) @(negedge clk);
        total++; if (grid_fg !== exp_fg[7] || base_addr !== exp_base[7]) begin bad++;
            $display("FAIL idle_hold: got %h %h want %h %h", grid_fg, base_addr, exp_fg[7], exp_base[7]); end
    endtask

    task automatic test_wrap();
        bit ok;
        int n0;
        done_lat = 3;
        random_setup();
        n0 = n_run;
        run_frame(20'hFFFF0, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_end: got timeout want frame_done"); end
        total++; if (obs_base[n0+3] !== 20'h00008) begin bad++;
            $display("FAIL wrap_base_c3: got %h want 00008", obs_base[n0+3]); end
        total++; if (obs_base[n0+4] !== exp_base[4]) begin bad++;
            $display("FAIL wrap_base_r1: got %h want %h", obs_base[n0+4], exp_base[4]); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int n0, f0;
        done_lat = 4;
        random_setup();
        n0 = n_run; f0 = fd_cnt;
        fb_base = 20'($urandom); fb_m = fb_base;
        build_model(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            fb_base  = 20'($urandom);
            spurious = !render_run && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (frame_done) begin ok = 1'b1; break; end
        end
        spurious = 1'b0;
        start = 1'b1;  // coincides with frame_done
        @(negedge clk);
        start = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL busy_end: got timeout want frame_done"); end
        for (int j = 0; j < 3; j++) begin
            total++; if (busy !== 1'b0) begin bad++;
                $display("FAIL start_at_fd%0d: got busy %b want 0", j, busy); end
            @(negedge clk);
        end
        total++; if (n_run - n0 != NCELL || fd_cnt - f0 != 1) begin bad++;
            $display("FAIL busy_counts: got %0d/%0d want %0d/1", n_run - n0, fd_cnt - f0, NCELL); end
        for (int i = 0; i < NCELL; i++) begin
            total++; if ({obs_fg[n0+i], obs_bg[n0+i], obs_base[n0+i], obs_shape[n0+i]} !==
                         {exp_fg[i], exp_bg[i], exp_base[i], exp_shape[i]}) begin bad++;
                $display("FAIL busy_cell%0d: got %h %h want %h %h", i, obs_fg[n0+i],
                         obs_base[n0+i], exp_fg[i], exp_base[i]); end
        end
    endtask

    task automatic wait_text_addr(input logic [11:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (text_addr == a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_palette_mid();
        bit ok1, ok2, ok3;
        int n0;
        done_lat = 4;
        random_setup();
        pal_write(4'd2, 32'h1234_5678);
        pal_write(4'd3, 32'h9ABC_DEF0);
        text_mem[2][11:8]  = 4'd2;
        text_mem[3][11:8]  = 4'd2;
        text_mem[4][15:12] = 4'd3;
        text_mem[5][15:12] = 4'd3;
        n0 = n_run;
        fb_base = 20'($urandom); fb_m = fb_base;
        build_model(0);
        pulse_start();
        wait_text_addr(12'd2, ok1);
        repeat (2) @(negedge clk);       // now in FONT of cell 2
        pal_write(4'd2, 32'hEDCB_A987);
        build_model(3);
        wait_text_addr(12'd4, ok2);
        @(negedge clk);                  // LATCH of cell 4: same-cycle write
        pal_write(4'd3, 32'h6543_210F);
        build_model(5);
        wait_frame(ok3);
        total++; if (!(ok1 && ok2 && ok3)) begin bad++;
            $display("FAIL pal_mid_flow: got %b%b%b want 111", ok1, ok2, ok3); end
        for (int i = 2; i < 6; i++) begin
            total++; if (obs_fg[n0+i] !== exp_fg[i] || obs_bg[n0+i] !== exp_bg[i]) begin bad++;
                $display("FAIL pal_mid_cell%0d: got %h/%h want %h/%h", i, obs_fg[n0+i],
                         obs_bg[n0+i], exp_fg[i], exp_bg[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        done_lat = 30;
        random_setup();
        fb_base = 20'($urandom); fb_m = fb_base;
        pulse_start();
        wait_text_addr(12'd2, ok);
        for (int i = 0; i < 100 && !render_run; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) pal_m[i] = '0;
        total++; if (!ok || render_run !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL async_rst: got run %b busy %b want 0 0", render_run, busy); end
        @(negedge clk);
        total++; if (text_addr !== 12'h0 || grid_fg !== 32'h0 || base_addr !== 20'h0) begin bad++;
            $display("FAIL rst_clear: got %h %h %h want 0", text_addr, grid_fg, base_addr); end
        rst = 1'b0;
        @(negedge clk);
        pal_write(4'($urandom), $urandom);
        n0 = n_run;
        run_frame(20'($urandom), ok);
        total++; if (!ok || n_run - n0 != NCELL) begin bad++;
            $display("FAIL restart_windows: got %0d want %0d", n_run - n0, NCELL); end
        for (int i = 0; i < NCELL; i++) begin
            total++; if ({obs_fg[n0+i], obs_bg[n0+i], obs_base[n0+i], obs_shape[n0+i]} !==
                         {exp_fg[i], exp_bg[i], exp_base[i], exp_shape[i]}) begin bad++;
                $display("FAIL restart_cell%0d: got %h %h want %h %h", i, obs_fg[n0+i],
                         obs_base[n0+i], exp_fg[i], exp_base[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_full_frame();
        test_wrap();
        test_busy_ignore();
        test_palette_mid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
